// File: rtl/reg_file_initiator.sv
// Register-file bus initiator: one command in flight, local address decode,
// credit-gated single-cycle request, ack timeout, one response per command.
module reg_file_initiator #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned CREDIT_MAX = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ERR_W-1:0]  rsp_err,
  output logic              o_req,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_ack,
  input  logic              i_credit,
  input  logic [ERR_W-1:0]  i_err
);

  localparam int unsigned CW = $clog2(CREDIT_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  ADDR_LO     = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0]  ADDR_HI     = (ADDR_W+1)'(BASE_ADDR + 4 * NUM_REGS);
  localparam logic [CW-1:0]    CMAX        = CW'(CREDIT_MAX);
  localparam logic [TW-1:0]    TMAX        = TW'(TIMEOUT);
  localparam logic [ERR_W-1:0] ERR_DECODE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = ERR_W'(2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   credits;
  logic [TW-1:0]   timer;
  logic            dec_ok;
  logic            accept;
  logic            issue;

  always_comb begin
    dec_ok = (cmd_addr[1:0] == 2'b00) &&
             ({1'b0, cmd_addr} >= ADDR_LO) &&
             ({1'b0, cmd_addr} <  ADDR_HI);
    // Decode failures never need a credit, so they are always accepted in IDLE.
    cmd_ready = !rst && (state == IDLE) && (!dec_ok || (credits != '0));
    accept    = cmd_valid && cmd_ready;
    issue     = (state == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      credits   <= CMAX;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
      o_req     <= 1'b0;
      o_wr      <= 1'b0;
      o_addr    <= '0;
      o_wr_data <= '0;
    end else begin
      // A return and a consume in the same cycle cancel, even at saturation.
      if (i_credit && !issue) begin
        if (credits != CMAX) credits <= credits + CW'(1);
      end else if (issue && !i_credit) begin
        credits <= credits - CW'(1);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_ok) begin
              o_req     <= 1'b1;
              o_wr      <= cmd_wr;
              o_addr    <= cmd_addr;
              o_wr_data <= cmd_wdata;
              state     <= ISSUE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= ERR_DECODE;
              state     <= RESP;
            end
          end
        end
        ISSUE: begin
          o_req <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (i_ack) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (!o_wr && (i_err == '0)) ? i_rd_data : '0;
            rsp_err   <= i_err;
            state     <= RESP;
          end else if (timer == TMAX) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= ERR_TIMEOUT;
            state     <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_initiator.sv
// Directed bench for reg_file_initiator: scoreboard of expected responses,
// cycle-exact checks of request, timeout, credit and reset behaviour.
module tb_reg_file_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_err;
  logic        o_req, o_wr;
  logic [31:0] o_addr, o_wr_data;
  logic [31:0] i_rd_data;
  logic        i_ack, i_credit;
  logic [7:0]  i_err;

  reg_file_initiator #(
    .ADDR_W(32), .DATA_W(32), .ERR_W(8), .NUM_REGS(8),
    .BASE_ADDR(0), .CREDIT_MAX(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_req(o_req), .o_wr(o_wr), .o_addr(o_addr), .o_wr_data(o_wr_data),
    .i_rd_data(i_rd_data), .i_ack(i_ack), .i_credit(i_credit), .i_err(i_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  e;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [8];
  int          total = 0;
  int          fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input int hold);
    exp_t        e;
    int          n;
    logic [31:0] d0;
    logic [7:0]  e0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e.d);
      chk("rsp_err", rsp_err, e.e);
    end
    d0 = rsp_rdata;
    e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, d0);
      chk("hold_err", rsp_err, e0);
      chk("hold_no_accept", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  // Full decoded transaction; the bench acts as the responder.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int ack_lat, input logic [7:0] errv, input logic credit,
                     input int hold, input logic [31:0] exp_d);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    #1;
    chk("txn_ready", cmd_ready, 1);
    sb.push_back('{d: exp_d, e: errv});
    step();
    cmd_valid = 1'b0;
    chk("req_high", o_req, 1);
    chk("req_wr", o_wr, wr);
    chk("req_addr", o_addr, addr);
    chk("req_wdata", o_wr_data, wdata);
    step();
    chk("req_pulse", o_req, 0);
    for (int i = 0; i < ack_lat; i++) begin
      step();
      chk("no_early_rsp", rsp_valid, 0);
    end
    i_ack     = 1'b1;
    i_err     = errv;
    i_credit  = credit;
    i_rd_data = wr ? 32'h1234_5678 : mem[addr[4:2]];
    if (wr && errv == 8'd0) mem[addr[4:2]] = wdata;
    step();
    i_ack    = 1'b0;
    i_err    = 8'd0;
    i_credit = 1'b0;
    chk("rsp_latency", rsp_valid, 1);
    collect(hold);
  endtask

  task automatic bad_cmd(input logic [31:0] addr);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = addr;
    #1;
    chk("bad_ready", cmd_ready, 1);
    sb.push_back('{d: 32'd0, e: 8'd1});
    step();
    cmd_valid = 1'b0;
    chk("bad_no_req", o_req, 0);
    chk("bad_rsp_n1", rsp_valid, 1);
    collect(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    rst = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h4; cmd_wdata = '0;
    rsp_ready = 1'b0; i_rd_data = '0; i_ack = 1'b0; i_credit = 1'b0; i_err = '0;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_o_req", o_req, 0);
    chk("rst_o_wr", o_wr, 0);
    chk("rst_o_addr", o_addr, 0);
    chk("rst_o_wr_data", o_wr_data, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    step();

    // Write then read back, plus a responder error and the top register.
    txn(1'b1, 32'h4, 32'hDEADBEEF, 0, 8'd0, 1'b1, 0, 32'd0);
    txn(1'b0, 32'h4, 32'd0, 2, 8'd0, 1'b1, 0, 32'hDEADBEEF);
    txn(1'b1, 32'h1C, 32'h0BADF00D, 1, 8'd5, 1'b1, 0, 32'd0);

    bad_cmd(32'h22);
    bad_cmd(32'h20);

    // Timeout: WAIT entry at W, response at W+17.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h8;
    #1;
    chk("to_ready", cmd_ready, 1);
    sb.push_back('{d: 32'd0, e: 8'd2});
    step();
    cmd_valid = 1'b0;
    chk("to_req", o_req, 1);
    step();
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("to_wait", rsp_valid, 0);
    end
    chk("to_addr_held", o_addr, 32'h8);
    step();
    chk("to_rsp_at_17", rsp_valid, 1);
    collect(0);
    step();
    step();
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
    chk("late_ack_ignored", rsp_valid, 0);
    step();
    chk("late_ack_ignored2", rsp_valid, 0);

    // Restore the lost credit, then two extra pulses that must saturate.
    for (int i = 0; i < 3; i++) begin
      i_credit = 1'b1;
      step();
      i_credit = 1'b0;
    end

    // Credit starvation: third command stalls until a credit returns.
    txn(1'b0, 32'h0, 32'd0, 0, 8'd0, 1'b0, 0, 32'd0);
    txn(1'b0, 32'h0, 32'd0, 0, 8'd0, 1'b0, 0, 32'd0);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h4;
    #1;
    chk("stall_ready", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready_loop", cmd_ready, 0);
      chk("stall_no_req", o_req, 0);
    end
    cmd_valid = 1'b0; cmd_addr = 32'h22;
    #1;
    chk("stall_bad_ready", cmd_ready, 1);
    cmd_addr = 32'h4; cmd_valid = 1'b1;
    i_credit = 1'b1;
    #1;
    chk("stall_pulse_cycle", cmd_ready, 0);
    sb.push_back('{d: 32'hDEADBEEF, e: 8'd0});
    step();
    i_credit = 1'b0;
    #1;
    chk("stall_release", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("stall_req", o_req, 1);
    step();
    i_ack = 1'b1; i_rd_data = mem[1]; i_credit = 1'b1;
    step();
    i_ack = 1'b0; i_credit = 1'b0;
    chk("stall_rsp", rsp_valid, 1);
    collect(0);

    // Back-pressure on the response.
    txn(1'b0, 32'h4, 32'd0, 0, 8'd0, 1'b0, 5, 32'hDEADBEEF);

    // Reset during WAIT abandons the transaction and refills credits.
    i_credit = 1'b1;
    step();
    i_credit = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hA5A5A5A5;
    #1;
    chk("rw_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("rw_req", o_req, 1);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rw_cmd_ready", cmd_ready, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_rsp_rdata", rsp_rdata, 0);
    chk("rw_rsp_err", rsp_err, 0);
    chk("rw_o_req", o_req, 0);
    chk("rw_o_wr", o_wr, 0);
    chk("rw_o_addr", o_addr, 0);
    chk("rw_o_wr_data", o_wr_data, 0);
    rst = 1'b0;
    step();
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
    chk("rw_no_rsp", rsp_valid, 0);
    step();
    chk("rw_no_rsp2", rsp_valid, 0);
    txn(1'b0, 32'h0, 32'd0, 0, 8'd0, 1'b0, 0, 32'd0);
    txn(1'b0, 32'h0, 32'd0, 0, 8'd0, 1'b0, 0, 32'd0);
    cmd_valid = 1'b1; cmd_addr = 32'h10;
    #1;
    chk("rw_credit_max", cmd_ready, 0);
    cmd_valid = 1'b0;
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
